// File: rtl/timer_pkg.sv
//==============================================================================
// Module      : timer_pkg
// Description : Shared widths, clock-select encodings and register map of the
//               8-bit APB timer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package timer_pkg;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned DIV_W = 4;

    typedef enum logic [1:0] {
        CKS_CLK2  = 2'b00,
        CKS_CLK4  = 2'b01,
        CKS_CLK8  = 2'b10,
        CKS_CLK16 = 2'b11
    } cks_e;

    localparam int unsigned TCR_LOAD    = 7;
    localparam int unsigned TCR_DW      = 5;
    localparam int unsigned TCR_EN      = 4;
    localparam int unsigned TCR_CKS_MSB = 1;
    localparam int unsigned TCR_CKS_LSB = 0;

    localparam int unsigned TSR_UDF = 1;
    localparam int unsigned TSR_OVF = 0;

    localparam logic [7:0] ADDR_TDR = 8'h00;
    localparam logic [7:0] ADDR_TCR = 8'h01;
    localparam logic [7:0] ADDR_TSR = 8'h02;

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
//==============================================================================
// Module      : timer_prescaler
// Description : Free-running pclk divider; emits a one-cycle count enable on
//               the rising edge of the selected divider bit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module timer_prescaler
    import timer_pkg::*;
(
    input  logic       pclk,
    input  logic       preset,
    input  logic [1:0] cks,
    output logic       tick
);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic             sel_prev_q;
    logic             sel_prev_d;
    logic             sel;

    // sel_prev follows whichever bit is currently selected, so a cks change
    // can disturb at most one edge and never stretches tick beyond one cycle.
    always_comb begin
        div_cnt_d  = div_cnt_q + DIV_W'(1);
        sel        = div_cnt_q[cks];
        sel_prev_d = sel;
        tick       = sel & ~sel_prev_q;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            div_cnt_q  <= '0;
            sel_prev_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            sel_prev_q <= sel_prev_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/timer_counter.sv
//==============================================================================
// Module      : timer_counter
// Description : Counting core of the APB timer: prescaled up/down count with
//               load and one-cycle overflow/underflow set pulses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module timer_counter
    import timer_pkg::*;
(
    input  logic             pclk,
    input  logic             preset,
    input  logic [CNT_W-1:0] tdr,
    input  logic             load,
    input  logic             dw,
    input  logic             en,
    input  logic [1:0]       cks,
    output logic [CNT_W-1:0] tcnt,
    output logic             tick,
    output logic             ovf_set,
    output logic             udf_set
);

    logic [CNT_W-1:0] tcnt_q;
    logic [CNT_W-1:0] tcnt_d;
    logic             ovf_set_q;
    logic             ovf_set_d;
    logic             udf_set_q;
    logic             udf_set_d;
    logic             w_tick;

    timer_prescaler u_prescaler (
        .pclk   (pclk),
        .preset (preset),
        .cks    (cks),
        .tick   (w_tick)
    );

    // Load wins over counting and swallows a coincident tick without a flag.
    always_comb begin
        tcnt_d    = tcnt_q;
        ovf_set_d = 1'b0;
        udf_set_d = 1'b0;
        if (load) begin
            tcnt_d = tdr;
        end else if (en && w_tick) begin
            if (!dw) begin
                ovf_set_d = (tcnt_q == {CNT_W{1'b1}});
                tcnt_d    = tcnt_q + CNT_W'(1);
            end else begin
                udf_set_d = (tcnt_q == {CNT_W{1'b0}});
                tcnt_d    = tcnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            tcnt_q    <= '0;
            ovf_set_q <= 1'b0;
            udf_set_q <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_d;
            ovf_set_q <= ovf_set_d;
            udf_set_q <= udf_set_d;
        end
    end

    assign tcnt    = tcnt_q;
    assign tick    = w_tick;
    assign ovf_set = ovf_set_q;
    assign udf_set = udf_set_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_counter.sv
//==============================================================================
// Module      : tb_timer_counter
// Description : Scoreboard bench for timer_counter against a cycle-count
//               reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_timer_counter;
    import timer_pkg::*;

    logic             pclk   = 1'b0;
    logic             preset = 1'b1;
    logic [CNT_W-1:0] tdr    = '0;
    logic             load   = 1'b0;
    logic             dw     = 1'b0;
    logic             en     = 1'b0;
    logic [1:0]       cks    = 2'b00;
    logic [CNT_W-1:0] tcnt;
    logic             tick;
    logic             ovf_set;
    logic             udf_set;

    timer_counter dut (
        .pclk    (pclk),
        .preset  (preset),
        .tdr     (tdr),
        .load    (load),
        .dw      (dw),
        .en      (en),
        .cks     (cks),
        .tcnt    (tcnt),
        .tick    (tick),
        .ovf_set (ovf_set),
        .udf_set (udf_set)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [7:0] tcnt;
        logic       tick;
        logic       ovf;
        logic       udf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: m_n is the number of pclk edges since reset release.
    int   m_n        = 0;
    int   m_cnt      = 0;
    bit   m_ovf      = 1'b0;
    bit   m_udf      = 1'b0;
    int   m_cks_prev = 0;

    function automatic bit div_bit(int n, int k);
        return bit'(((n % 16) >> k) & 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_n = 0; m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0; m_cks_prev = 0;
    endtask

    // Called at posedge+1: apply inputs, predict this cycle's outputs, advance.
    task automatic step(input bit l, input int d, input bit w, input bit e, input int c);
        exp_t ex;
        bit   tick_e;
        load = l; tdr = 8'(d); dw = w; en = e; cks = 2'(c);
        tick_e  = div_bit(m_n, c) && !(m_n > 0 && div_bit(m_n - 1, m_cks_prev));
        ex.tcnt = 8'(m_cnt);
        ex.tick = tick_e;
        ex.ovf  = m_ovf;
        ex.udf  = m_udf;
        sb.push_back(ex);
        m_ovf = 1'b0;
        m_udf = 1'b0;
        if (l) begin
            m_cnt = d % 256;
        end else if (e && tick_e) begin
            if (!w) begin
                m_ovf = (m_cnt == 255);
                m_cnt = (m_cnt + 1) % 256;
            end else begin
                m_udf = (m_cnt == 0);
                m_cnt = (m_cnt + 255) % 256;
            end
        end
        m_n++;
        m_cks_prev = c;
        @(posedge pclk);
        #1;
    endtask

    task automatic run(input int cycles, input bit w, input bit e, input int c);
        for (int i = 0; i < cycles; i++) step(1'b0, 0, w, e, c);
    endtask

    task automatic mid_reset();
        preset = 1'b1;
        #1;
        check("rst_tcnt", int'(tcnt), 0);
        check("rst_ovf", int'(ovf_set), 0);
        check("rst_udf", int'(udf_set), 0);
        check("rst_tick", int'(tick), 0);
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk);
            #1;
        end
        model_reset();
        preset = 1'b0;
    endtask

    always @(negedge pclk) begin
        exp_t e;
        if (!preset && sb.size() > 0) begin
            e = sb.pop_front();
            check("tcnt", int'(tcnt), int'(e.tcnt));
            check("tick", int'(tick), int'(e.tick));
            check("ovf_set", int'(ovf_set), int'(e.ovf));
            check("udf_set", int'(udf_set), int'(e.udf));
        end
    end

    initial begin
        bit r_load, r_dw, r_en;
        int r_cks;
        repeat (3) @(posedge pclk);
        #1;
        model_reset();
        preset = 1'b0;

        run(8, 1'b0, 1'b0, 0);

        // Down count through underflow at clk8
        step(1'b1, 8'hFF, 1'b0, 1'b0, 2);
        run(2100, 1'b1, 1'b1, 2);

        // Up count through overflow at clk2
        step(1'b1, 8'hFE, 1'b0, 1'b0, 0);
        run(10, 1'b0, 1'b1, 0);

        // Load held across a tick cycle
        step(1'b1, 8'h10, 1'b0, 1'b1, 0);
        step(1'b1, 8'h10, 1'b0, 1'b1, 0);
        run(6, 1'b0, 1'b1, 0);

        // Enable gating
        step(1'b1, 8'h42, 1'b0, 1'b0, 1);
        run(100, 1'b0, 1'b0, 1);
        run(20, 1'b0, 1'b1, 1);

        // cks sweep, then a mid-period switch from clk16 to clk2
        for (int c = 0; c < 4; c++) run(40, 1'b0, 1'b1, c);
        run(5, 1'b0, 1'b1, 3);
        run(20, 1'b0, 1'b1, 0);

        mid_reset();
        run(8, 1'b0, 1'b1, 0);

        r_dw = 1'b0; r_en = 1'b1; r_cks = 0;
        for (int i = 0; i < 3000; i++) begin
            r_load = ($urandom_range(15) == 0);
            if ($urandom_range(31) == 0) r_dw  = ~r_dw;
            if ($urandom_range(31) == 0) r_en  = ~r_en;
            if ($urandom_range(63) == 0) r_cks = int'($urandom_range(3));
            step(r_load, int'($urandom_range(255)), r_dw, r_en, r_cks);
        end

        @(negedge pclk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Counting core of the 8-bit APB timer. It sits directly downstream of the APB register block, which drives TDR and TCR fields into it.
- Contains the pclk prescaler, which selects clk2, clk4, clk8 or clk16 count enables.
- Maintains the 8-bit count (TCNT) and emits one-cycle overflow/underflow set pulses. The register block accumulates these pulses into sticky TSR bits.

Parameters:
- CNT_W, 8, counter width. TDR/TCNT width.
- DIV_W, 4, prescaler width. Supports divide by 2^(cks+1), cks in 0..3.

Ports:
- pclk  in  1  system clock, sole clock.
- preset  in  1  asynchronous active-high reset.
- tdr  in  CNT_W  load value (TDR register).
- load  in  1  TCR[7]; load request, level-sensitive.
- dw  in  1  TCR[5]; 0 = count up, 1 = count down.
- en  in  1  TCR[4]; count enable.
- cks  in  2  TCR[1:0]; 00 clk2, 01 clk4, 10 clk8, 11 clk16.
- tcnt  out  CNT_W  current count.
- tick  out  1  selected prescaled count enable, one pclk wide.
- ovf_set  out  1  one-cycle pulse on up-count wrap 0xFF->0x00.
- udf_set  out  1  one-cycle pulse on down-count wrap 0x00->0xFF.

Behaviour:
- Reset (async, preset=1): div_cnt=0, sel_prev=0, tcnt=0x00, ovf_set=0, udf_set=0. tick reads 0.
- Prescaler:
  - div_cnt (DIV_W bits) increments every pclk, free-running, wraps 0xF->0x0.
  - It is unaffected by en and load.
- Tick:
  - sel = div_cnt[cks]; sel_prev <= sel each cycle.
  - tick = sel & ~sel_prev (combinational from registers).
  - Period is 2^(cks+1) pclk. The first tick after reset occurs when div_cnt first equals 2^cks.
- cks change mid-operation: sel_prev tracks the newly selected bit from the next cycle. At most one extra or one missed tick in the change window, no multi-cycle tick. The new period applies from the following tick.
- Counter update at pclk edge, priority order:
  1. load=1: tcnt <= tdr, regardless of en/tick. No ovf/udf pulse. A coincident tick is discarded.
  2. en=1 & tick=1 & dw=0: tcnt <= tcnt+1, modulo 2^CNT_W.
  3. en=1 & tick=1 & dw=1: tcnt <= tcnt-1, modulo 2^CNT_W.
  4. Otherwise hold.
- Flags:
  - ovf_set <= (case 2 and tcnt==all-ones).
  - udf_set <= (case 3 and tcnt==0).
  - Each flag is high for exactly the one cycle following the wrapping edge, concurrent with the new tcnt value. Both are 0 otherwise and are never high together.
- Load held high: tcnt tracks tdr with 1-cycle latency each cycle; counting is suppressed while load=1.
- en falling: tcnt holds; the prescaler keeps running (no resync on re-enable).
- dw change between ticks takes effect on the next tick. No flag is generated from a direction change alone.
- Latency: tick-to-tcnt is 1 pclk; tcnt-to-flag alignment is the same edge.
- Reset asserted mid-count: all state clears immediately (async). Counting resumes from div_cnt=0 after deassertion.

Decomposition:
- Shared package timer_pkg:
  - CNT_W and DIV_W.
  - CKS encodings CKS_CLK2/4/8/16.
  - TCR bit positions (TCR_LOAD=7, TCR_DW=5, TCR_EN=4, TCR_CKS=1:0) and TSR bit positions (TSR_UDF=1, TSR_OVF=0).
  - Register addresses TDR=0x00, TCR=0x01, TSR=0x02.
- One sub-module: timer_prescaler (div_cnt, sel_prev, tick generation). timer_counter instantiates it and holds the count/flag logic.

Test Plan:
- Reset: preset=1 mid-run -> tcnt=0x00, ovf_set=0, udf_set=0, tick=0 immediately. With cks=00 after release, first tick at 1 pclk, then every 2 pclk.
- Down count, clk8: tdr=0xFF, load=1 for 1 cycle -> tcnt=0xFF. Then dw=1, en=1, cks=10 -> tcnt=0x00 after 255 ticks. udf_set pulses once on the 256th tick (~2048 pclk); tcnt=0xFF and ovf_set stays 0.
- Up count, clk2: tdr=0xFE, load, then dw=0, en=1, cks=00 -> tcnt 0xFF then 0x00. ovf_set high exactly the cycle tcnt becomes 0x00, about 4 pclk after enable.
- Load vs tick collision: load=1 with tdr=0x10 on a tick cycle, en=1 -> tcnt=0x10 next cycle, no increment, no flag.
- Enable gating: en=0 for 100 pclk at tcnt=0x42 -> tcnt stays 0x42. Re-enable -> counts resume on the next prescaler tick.
- cks sweep 00/01/10/11 -> measured tick periods are 2/4/8/16 pclk. A switch from 11 to 00 mid-period yields no tick wider than 1 pclk.
